// File: rtl/cosim_drv_pkg.sv
// cosim_drv_pkg
// Shared definitions for the cosim vector driver:
//   - state_e      : driver FSM states
//   - DEFAULT_POLY : default Galois feedback taps (x^128+x^7+x^2+x+1 low part)
//   - MAX_W        : widest bus the shared step function supports
//   - galois_next  : one Galois LFSR/MISR step, shared by the LFSR and the MISR
package cosim_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_W = 256;

  localparam logic [7:0] DEFAULT_POLY = 8'h87;

  // next(x) = {x[w-2:0],0} ^ (x[w-1] ? poly : 0), computed on a MAX_W-wide
  // container so one function serves every bus width. Bits at or above w are
  // forced to zero; w is a constant at every call site, so this folds away.
  function automatic logic [MAX_W-1:0] galois_next(
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] poly,
    input int               w
  );
    logic [MAX_W-1:0] y;
    logic             msb;
    y   = {x[MAX_W-2:0], 1'b0};
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= w) begin
        y[i] = 1'b0;
      end else begin
        y[i] = y[i];
      end
      if (i == w - 1) begin
        msb = x[i];
      end else begin
        msb = msb;
      end
    end
    if (msb) begin
      y = y ^ poly;
    end else begin
      y = y;
    end
    return y;
  endfunction

endpackage

// File: rtl/cosim_misr.sv
// cosim_misr
// Response compactor: a Galois MISR signature plus a bitwise sticky-OR
// accumulator of every captured response word.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero both registers (wins over en)
//   en         : capture data into the signature and accumulator
//   data       : response word to capture
//   sig        : MISR signature
//   or_acc     : OR of every captured word since the last clear
module cosim_misr
  import cosim_drv_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] or_acc
);

  localparam logic [MAX_W-1:0] POLY_X = MAX_W'(POLY);

  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] or_acc_q, or_acc_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    logic [MAX_W-1:0] r;
    r = galois_next(MAX_W'(x), POLY_X, WIDTH);
    return r[WIDTH-1:0];
  endfunction

  // Next-state selection: clear, capture or hold.
  always_comb begin
    sig_d    = sig_q;
    or_acc_d = or_acc_q;
    if (clr) begin
      sig_d    = '0;
      or_acc_d = '0;
    end else if (en) begin
      sig_d    = step(sig_q) ^ data;
      or_acc_d = or_acc_q | data;
    end else begin
      sig_d    = sig_q;
      or_acc_d = or_acc_q;
    end
  end

  // Signature and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= '0;
      or_acc_q <= '0;
    end else begin
      sig_q    <= sig_d;
      or_acc_q <= or_acc_d;
    end
  end

  assign sig    = sig_q;
  assign or_acc = or_acc_q;

endmodule

// File: rtl/cosim_vec_driver.sv
// cosim_vec_driver
// Drives a pseudo-random vector stream onto a combinational DUT, holds each
// vector for SETTLE cycles, samples the response on the last cycle and folds
// it into a MISR signature and a sticky-OR accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (accepted only when not busy)
//   abort      : end the current run early (only while busy)
//   dut_in     : registered stimulus;  dut_out : DUT response
//   busy/done/aborted : run status, done/aborted held until next start
//   vec_count  : vectors sampled in the current or last run
//   sig/or_acc : MISR signature and OR of all sampled responses
module cosim_vec_driver
  import cosim_drv_pkg::*;
#(
  parameter int               WIDTH    = 128,
  parameter int               NUM_VECS = 256,
  parameter int               SETTLE   = 1,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1'b1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      vec_count,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] or_acc
);

  localparam logic [MAX_W-1:0] POLY_X   = MAX_W'(POLY);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
  localparam int               SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_RELOAD = SW'(SETTLE - 1);
  localparam logic [15:0]      NUM_VECS_L    = 16'(NUM_VECS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dut_in_q, dut_in_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             misr_en;
  logic             misr_clr;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    logic [MAX_W-1:0] r;
    r = galois_next(MAX_W'(x), POLY_X, WIDTH);
    return r[WIDTH-1:0];
  endfunction

  // FSM next state: start loads the first vector, each sample edge either
  // advances to the next LFSR vector or finishes; abort beats a sample.
  always_comb begin
    state_d     = state_q;
    dut_in_d    = dut_in_q;
    lfsr_d      = lfsr_q;
    settle_d    = settle_q;
    vec_count_d = vec_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    misr_en     = 1'b0;
    misr_clr    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          dut_in_d    = SEED_EFF;
          lfsr_d      = step(SEED_EFF);
          settle_d    = SETTLE_RELOAD;
          vec_count_d = 16'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          aborted_d   = 1'b0;
          misr_clr    = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (settle_q != '0) begin
          settle_d = settle_q - SW'(1);
        end else begin
          misr_en     = 1'b1;
          vec_count_d = vec_count_q + 16'd1;
          if (vec_count_d == NUM_VECS_L) begin
            // Last vector stays on dut_in after the run.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            dut_in_d = lfsr_q;
            lfsr_d   = step(lfsr_q);
            settle_d = SETTLE_RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM, stimulus and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dut_in_q    <= '0;
      lfsr_q      <= SEED_EFF;
      settle_q    <= '0;
      vec_count_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dut_in_q    <= dut_in_d;
      lfsr_q      <= lfsr_d;
      settle_q    <= settle_d;
      vec_count_q <= vec_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  cosim_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (misr_clr),
    .en     (misr_en),
    .data   (dut_out),
    .sig    (sig),
    .or_acc (or_acc)
  );

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign vec_count = vec_count_q;

endmodule

// File: doc/cosim_vec_driver.md
Name: cosim_vec_driver

Overview:
- Sequential stimulus/response driver for the combinational gate cosims.
- Generates a pseudo-random WIDTH-bit vector stream onto a DUT `in` bus and samples the DUT `out` bus after a fixed settle time.
- Compacts responses into a MISR signature and a bitwise sticky-OR accumulator.
- Sits in the cosim harness as the opposite end of the spec's in/out interface: it drives `in` and consumes `out`.

Parameters:
- WIDTH, 128, width of the dut_in, dut_out, signature and accumulator buses.
- NUM_VECS, 256, number of vectors per run; legal range 1..2^16-1.
- SETTLE, 1, cycles each vector is held before dut_out is sampled; must be >= 1.
- POLY, 'h87, Galois feedback taps shared by LFSR and MISR (x^128+x^7+x^2+x+1).
- SEED, 1, initial LFSR value; a SEED of 0 is replaced by 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a run
- abort  input  1  terminate the current run
- dut_in  output  WIDTH  registered stimulus to the DUT
- dut_out  input  WIDTH  DUT response, combinational from dut_in
- busy  output  1  run in progress
- done  output  1  run completed; held until the next accepted start
- aborted  output  1  last run ended by abort; held until the next accepted start
- vec_count  output  16  number of vectors sampled in the current or last run
- sig  output  WIDTH  MISR signature
- or_acc  output  WIDTH  bitwise OR of every sampled dut_out

Behaviour:
- Reset: one clock, asynchronous and active-low: clk, rst_n. While rst_n=0, every register clears asynchronously:
  - state=IDLE; dut_in, sig, or_acc, vec_count all 0; busy, done, aborted 0.
  - LFSR=SEED' and settle counter=0.
- Reset mid-run: same as above; no partial results are retained.
- next(x) = {x[W-2:0],0} ^ (x[W-1] ? POLY : 0).
- States: IDLE, DRIVE, DONE.
- IDLE/DONE, start=1 sampled: go to DRIVE and load, in the same edge:
  - dut_in=SEED', LFSR=next(SEED'), sig=0, or_acc=0, vec_count=0;
  - busy=1, done=0, aborted=0, settle counter=SETTLE-1.
- DRIVE, settle counter>0: decrement it; dut_in holds.
- DRIVE, settle counter=0 (sample edge):
  - sig = next(sig) ^ dut_out; or_acc |= dut_out; vec_count+1.
  - If the new vec_count = NUM_VECS: go to DONE, busy=0, done=1; dut_in holds the last vector.
  - Otherwise: dut_in=LFSR, LFSR=next(LFSR), settle counter reloads to SETTLE-1.
- Timing: each vector occupies exactly SETTLE cycles. busy rises 1 cycle after start and falls NUM_VECS*SETTLE cycles after that.
- start while busy: ignored.
- abort while busy (takes priority over a sample on the same edge):
  - go to DONE, busy=0, done=1, aborted=1;
  - sig, or_acc and vec_count freeze at their pre-edge values.
- abort while not busy: ignored.
- start and abort together in IDLE/DONE: start wins.
- vec_count is 16 bits; NUM_VECS is restricted so it cannot wrap.
- All outputs are registered. dut_out is sampled only on sample edges.

Decomposition:
- Package cosim_drv_pkg:
  - state enum {IDLE, DRIVE, DONE};
  - default POLY constant;
  - galois_next function, shared by LFSR and MISR.
- One sub-module, cosim_misr: sig and or_acc registers with enable, clear and data inputs. The LFSR and FSM stay in the top module.

Test Plan:
- SEED=1, SETTLE=1, NUM_VECS=3, dut_out tied to 0, start -> dut_in=1,2,4 on consecutive cycles; busy high for 3 cycles; done=1; sig=0; or_acc=0; vec_count=3.
- Loopback dut_out=dut_in, NUM_VECS=2 -> sig=1 after the first sample and 0 after the second; or_acc=3.
- NUM_VECS=129, dut_out tied to 0 -> the 129th vector driven is 'h87 (LFSR wrap through POLY).
- SETTLE=3, NUM_VECS=2, dut_out toggling each cycle -> only cycles 3 and 6 after start are sampled; busy is high for 6 cycles.
- abort on the same cycle as the second sample edge, NUM_VECS=4 -> aborted=1, vec_count=1; sig and or_acc reflect vector 0 only. Then start -> aborted=0 and a fresh run yields the same vectors.
- Deassert rst_n mid-run, then start again -> all outputs are 0 during reset; the rerun produces a signature identical to an uninterrupted run.
